sweep_scheduler: RTL and testbench

- Sequences one Update_Element instance over columns j = 0..J-1 to form a coordinate-descent sweep; repeats sweeps until convergence or MAX_ITER.
- Owns the residual vector r, chains the running max_xj/max_dxj between columns, and issues xhat write-backs to the column store.
- Sits between the top-level solver control and the element datapath.

---
 rtl/sweep_scheduler_if.sv | 33 +++
 rtl/sweep_scheduler.sv | 160 ++++++++++++++++
 tb/tb_sweep_scheduler.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sweep_scheduler_if.sv
// Element/store-side bundle of the sweep scheduler: launch handshake, chained
// maxima, residual in/out and the xhat write-back port.
interface sweep_scheduler_if #(
    parameter int N  = 32,
    parameter int I  = 20,
    parameter int JW = 4
);
    logic                  ue_start;
    logic [JW-1:0]         ue_col;
    logic [0:I-1][N-1:0]   r_cur;
    logic [N-1:0]          max_xj_chain;
    logic [N-1:0]          max_dxj_chain;
    logic                  ue_done;
    logic [0:I-1][N-1:0]   ue_r_out;
    logic [N-1:0]          ue_xhat;
    logic [N-1:0]          ue_max_xj;
    logic [N-1:0]          ue_max_dxj;
    logic                  xhat_we;
    logic [JW-1:0]         xhat_addr;
    logic [N-1:0]          xhat_wdata;

    modport master (
        output ue_start, ue_col, r_cur, max_xj_chain, max_dxj_chain,
               xhat_we, xhat_addr, xhat_wdata,
        input  ue_done, ue_r_out, ue_xhat, ue_max_xj, ue_max_dxj
    );

    modport slave (
        input  ue_start, ue_col, r_cur, max_xj_chain, max_dxj_chain,
               xhat_we, xhat_addr, xhat_wdata,
        output ue_done, ue_r_out, ue_xhat, ue_max_xj, ue_max_dxj
    );
endinterface

// File: rtl/sweep_scheduler.sv
// Coordinate-descent sweep sequencer: walks columns through one element, owns the
// residual and chained maxima. Define SWEEP_SCHEDULER_ABORT_EN to add an abort input.
module sweep_scheduler #(
    parameter int I         = 20,
    parameter int J         = 16,
    parameter int Q         = 15,
    parameter int N         = 32,
    parameter int MAX_ITER  = 64,
    parameter int TOL_SHIFT = 8,
    parameter int JW        = (J > 1) ? $clog2(J) : 1,
    parameter int KW        = $clog2(MAX_ITER + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [0:I-1][N-1:0]  r_init,
`ifdef SWEEP_SCHEDULER_ABORT_EN
    input  logic                 abort,
`endif
    sweep_scheduler_if.master    ue,
    output logic [KW-1:0]        sweeps,
    output logic                 converged,
    output logic                 busy,
    output logic                 done
);

    if (J < 1 || TOL_SHIFT >= N || Q >= N - 1) begin : g_param_check
        $error("sweep_scheduler: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_NEXT,
        S_CHECK,
        S_FINISH
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [0:I-1][N-1:0]  r_q;
    logic [JW-1:0]        col;
    logic [N-1:0]         max_xj_q;
    logic [N-1:0]         max_dxj_q;
    logic                 ue_done_q;
    logic                 done_rise;
    logic                 write_back;
    logic                 last_col;
    logic                 tol_met;
    logic                 abort_req;
    logic [N-2:0]         mag_xj;
    logic [N-2:0]         mag_dxj;

`ifdef SWEEP_SCHEDULER_ABORT_EN
    assign abort_req = abort && (state != S_IDLE);
`else
    assign abort_req = 1'b0;
`endif

    // The element holds done high, so only its rising edge marks completion.
    assign done_rise = ue.ue_done && !ue_done_q;
    assign last_col  = (col == JW'(J - 1));
    assign mag_xj    = max_xj_q[N-2:0];
    assign mag_dxj   = max_dxj_q[N-2:0];
    assign tol_met   = (mag_dxj <= (mag_xj >> TOL_SHIFT)) ||
                       ((mag_xj == '0) && (mag_dxj == '0));

    always_comb begin
        state_nxt  = state;
        write_back = 1'b0;
        case (state)
            S_IDLE:   if (start) state_nxt = S_LAUNCH;
            S_LAUNCH: state_nxt = S_WAIT;
            S_WAIT: begin
                if (done_rise) begin
                    write_back = 1'b1;
                    state_nxt  = S_NEXT;
                end
            end
            S_NEXT:   state_nxt = last_col ? S_CHECK : S_LAUNCH;
            S_CHECK: begin
                if (tol_met || (sweeps == KW'(MAX_ITER)))
                    state_nxt = S_FINISH;
                else
                    state_nxt = S_LAUNCH;
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (abort_req && (state != S_FINISH)) begin
            state_nxt  = S_FINISH;
            write_back = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            r_q       <= '0;
            col       <= '0;
            sweeps    <= '0;
            max_xj_q  <= '0;
            max_dxj_q <= '0;
            converged <= 1'b0;
            ue_done_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            ue_done_q <= ue.ue_done;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        r_q       <= r_init;
                        col       <= '0;
                        sweeps    <= '0;
                        max_xj_q  <= '0;
                        max_dxj_q <= '0;
                        converged <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (write_back) begin
                        r_q       <= ue.ue_r_out;
                        max_xj_q  <= ue.ue_max_xj;
                        max_dxj_q <= ue.ue_max_dxj;
                    end
                end
                S_NEXT: begin
                    if (!abort_req) begin
                        if (last_col) sweeps <= sweeps + 1'b1;
                        else          col    <= col + 1'b1;
                    end
                end
                S_CHECK: begin
                    // Each sweep restarts the running maxima from zero.
                    if (state_nxt == S_LAUNCH) begin
                        col       <= '0;
                        max_xj_q  <= '0;
                        max_dxj_q <= '0;
                    end else if (tol_met && !abort_req) begin
                        converged <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ue.ue_start      = (state == S_LAUNCH);
    assign ue.ue_col        = col;
    assign ue.r_cur         = r_q;
    assign ue.max_xj_chain  = max_xj_q;
    assign ue.max_dxj_chain = max_dxj_q;
    assign ue.xhat_we       = write_back;
    assign ue.xhat_addr     = col;
    assign ue.xhat_wdata    = write_back ? ue.ue_xhat : '0;
    assign busy             = (state != S_IDLE);
    assign done             = (state == S_FINISH);

endmodule

// File: tb/tb_sweep_scheduler.sv
// Directed bench for sweep_scheduler with a behavioural element stub (latency,
// done-hold and convergence profile selectable per test).
module tb_sweep_scheduler;

    localparam int I         = 4;
    localparam int J         = 4;
    localparam int Q         = 15;
    localparam int N         = 32;
    localparam int MAX_ITER  = 4;
    localparam int TOL_SHIFT = 8;
    localparam int JW        = 2;
    localparam int KW        = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [0:I-1][N-1:0] r_init;
    logic [KW-1:0]       sweeps;
    logic                converged;
    logic                busy;
    logic                done;
`ifdef SWEEP_SCHEDULER_ABORT_EN
    logic                abort;
`endif

    sweep_scheduler_if #(.N(N), .I(I), .JW(JW)) bus ();

    sweep_scheduler #(
        .I(I), .J(J), .Q(Q), .N(N), .MAX_ITER(MAX_ITER),
        .TOL_SHIFT(TOL_SHIFT), .JW(JW), .KW(KW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .r_init    (r_init),
`ifdef SWEEP_SCHEDULER_ABORT_EN
        .abort     (abort),
`endif
        .ue        (bus),
        .sweeps    (sweeps),
        .converged (converged),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int testsRun = 0;
    int testsFailed = 0;

    int stubMode = 0;
    int stubLatency = 5;
    int stubHold = 1;
    int latCnt, holdCnt, stubCol, stubSweep, runLaunch;
    logic stubFresh;
    logic stubCompleting;

    int launchCount = 0;
    int writeCount = 0;
    int badWriteCount = 0;
    int doneCount = 0;
    int wrAddr[$];
    logic [N-1:0] wrData[$];

    // Element stub: returns after stubLatency cycles and keeps done high for stubHold cycles.
    assign stubCompleting = !bus.ue_start && (latCnt == 1);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            latCnt    <= 0;
            holdCnt   <= 0;
            stubCol   <= 0;
            stubSweep <= 0;
            runLaunch <= 0;
            stubFresh <= 1'b0;
        end else begin
            if (start && !busy) runLaunch <= 0;
            if (bus.ue_start) begin
                latCnt    <= stubLatency;
                stubCol   <= int'(bus.ue_col);
                stubSweep <= runLaunch / J;
                runLaunch <= runLaunch + 1;
                stubFresh <= 1'b0;
            end else if (latCnt == 1) begin
                latCnt    <= 0;
                stubFresh <= 1'b1;
            end else if (latCnt != 0) begin
                latCnt <= latCnt - 1;
            end
            if (stubCompleting)   holdCnt <= stubHold;
            else if (holdCnt != 0) holdCnt <= holdCnt - 1;
        end
    end

    assign bus.ue_done   = (holdCnt != 0);
    assign bus.ue_xhat   = N'(stubCol + 1);
    assign bus.ue_max_xj = 32'h0000_8000;

    always_comb begin
        bus.ue_max_dxj = 32'h0000_0081;
        case (stubMode)
            0:       bus.ue_max_dxj = 32'h0000_0000;
            1:       bus.ue_max_dxj = (stubSweep < 2) ? 32'h0000_0100 : 32'h8000_0080;
            default: bus.ue_max_dxj = 32'h0000_0081;
        endcase
    end

    always_comb begin
        bus.ue_r_out = '0;
        for (int i = 0; i < I; i++) bus.ue_r_out[i] = bus.r_cur[i] + 32'd1;
    end

    always @(negedge clk) begin
        if (bus.ue_start) launchCount++;
        if (bus.xhat_we) begin
            writeCount++;
            wrAddr.push_back(int'(bus.xhat_addr));
            wrData.push_back(bus.xhat_wdata);
            if (!stubFresh || int'(bus.xhat_addr) != stubCol ||
                bus.xhat_wdata != N'(stubCol + 1))
                badWriteCount++;
        end
        if (done) doneCount++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int mode, input int lat, input int hold);
        stubMode    = mode;
        stubLatency = lat;
        stubHold    = hold;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic waitForDone(input int budget, input string tag);
        bit seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput({tag, "_done_seen"}, 64'(seen), 64'd1);
        repeat (2) tick();
    endtask

    task automatic waitLaunches(input int base, input int target, input string tag);
        bit reached = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (launchCount - base >= target) begin
                reached = 1'b1;
                break;
            end
            tick();
        end
        checkOutput({tag, "_reached"}, 64'(reached), 64'd1);
    endtask

    initial begin
        int lb, wb, db;
        rst    = 1'b1;
        start  = 1'b0;
        r_init = '0;
`ifdef SWEEP_SCHEDULER_ABORT_EN
        abort  = 1'b0;
`endif
        repeat (3) tick();
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_sweeps", 64'(sweeps), 64'd0);
        checkOutput("rst_converged", 64'(converged), 64'd0);
        checkOutput("rst_ue_start", 64'(bus.ue_start), 64'd0);
        checkOutput("rst_xhat_we", 64'(bus.xhat_we), 64'd0);
        checkOutput("rst_r_cur0", 64'(bus.r_cur[0]), 64'd0);
        checkOutput("rst_max_xj", 64'(bus.max_xj_chain), 64'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Converges after one sweep; xhat written 1..4 at 0..3
        r_init = {32'h10, 32'h20, 32'h30, 32'h40};
        lb = launchCount; wb = writeCount; db = doneCount;
        applyStimulus(0, 5, 1);
        waitForDone(400, "t1");
        checkOutput("t1_sweeps", 64'(sweeps), 64'd1);
        checkOutput("t1_converged", 64'(converged), 64'd1);
        checkOutput("t1_launches", 64'(launchCount - lb), 64'd4);
        checkOutput("t1_writes", 64'(writeCount - wb), 64'd4);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("t1_addr%0d", k), 64'(wrAddr[wb + k]), 64'(k));
            checkOutput($sformatf("t1_data%0d", k), 64'(wrData[wb + k]), 64'(k + 1));
        end
        checkOutput("t1_r0", 64'(bus.r_cur[0]), 64'h14);
        checkOutput("t1_r3", 64'(bus.r_cur[3]), 64'h44);
        repeat (3) tick();
        checkOutput("t1_converged_hold", 64'(converged), 64'd1);
        checkOutput("t1_done_pulses", 64'(doneCount - db), 64'd1);
        checkOutput("t1_busy_after", 64'(busy), 64'd0);

        // Tolerance met exactly on sweep 3 with a negative-signed dxj
        lb = launchCount;
        applyStimulus(1, 5, 1);
        waitForDone(1000, "t2");
        checkOutput("t2_sweeps", 64'(sweeps), 64'd3);
        checkOutput("t2_converged", 64'(converged), 64'd1);
        checkOutput("t2_launches", 64'(launchCount - lb), 64'd12);
        checkOutput("t2_max_xj", 64'(bus.max_xj_chain), 64'h0000_8000);
        checkOutput("t2_max_dxj", 64'(bus.max_dxj_chain), 64'h8000_0080);

        // Never converges: stops at MAX_ITER
        lb = launchCount; wb = writeCount;
        applyStimulus(2, 5, 1);
        waitForDone(1500, "t3");
        checkOutput("t3_sweeps", 64'(sweeps), 64'd4);
        checkOutput("t3_converged", 64'(converged), 64'd0);
        checkOutput("t3_launches", 64'(launchCount - lb), 64'd16);
        checkOutput("t3_writes", 64'(writeCount - wb), 64'd16);
        checkOutput("t3_r0", 64'(bus.r_cur[0]), 64'h20);

        // done held high long after completion
        lb = launchCount; wb = writeCount;
        applyStimulus(0, 14, 10);
        waitForDone(800, "t4");
        checkOutput("t4_launches", 64'(launchCount - lb), 64'd4);
        checkOutput("t4_writes", 64'(writeCount - wb), 64'd4);
        checkOutput("t4_sweeps", 64'(sweeps), 64'd1);
        checkOutput("t4_bad_writes", 64'(badWriteCount), 64'd0);

        // Reset while waiting on column 2
        lb = launchCount; wb = writeCount;
        applyStimulus(2, 5, 1);
        waitLaunches(lb, 3, "t5_col2");
        checkOutput("t5_col", 64'(bus.ue_col), 64'd2);
        tick();
        rst = 1'b1;
        tick();
        checkOutput("t5_busy", 64'(busy), 64'd0);
        checkOutput("t5_r_cleared", 64'(bus.r_cur[0]), 64'd0);
        rst = 1'b0;
        repeat (8) tick();
        checkOutput("t5_writes", 64'(writeCount - wb), 64'd2);
        r_init = {32'h100, 32'h200, 32'h300, 32'h400};
        applyStimulus(0, 5, 1);
        checkOutput("t5_restart_launch", 64'(bus.ue_start), 64'd1);
        checkOutput("t5_restart_col", 64'(bus.ue_col), 64'd0);
        checkOutput("t5_restart_r2", 64'(bus.r_cur[2]), 64'h300);
        waitForDone(400, "t5");
        checkOutput("t5_sweeps", 64'(sweeps), 64'd1);
        checkOutput("t5_r2_final", 64'(bus.r_cur[2]), 64'h304);

`ifdef SWEEP_SCHEDULER_ABORT_EN
        // Abort while waiting on column 1 of sweep 2
        lb = launchCount; wb = writeCount;
        applyStimulus(2, 5, 1);
        waitLaunches(lb, 6, "t6_col1");
        checkOutput("t6_col", 64'(bus.ue_col), 64'd1);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("t6_done", 64'(done), 64'd1);
        checkOutput("t6_converged", 64'(converged), 64'd0);
        checkOutput("t6_sweeps", 64'(sweeps), 64'd1);
        repeat (20) tick();
        checkOutput("t6_writes", 64'(writeCount - wb), 64'd5);
        checkOutput("t6_busy", 64'(busy), 64'd0);
`endif

        checkOutput("all_bad_writes", 64'(badWriteCount), 64'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
